uart_rx_frame: RTL
==================

UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter OVERSAMPLE, default 16, meaning rx_tick pulses per bit period (even values 8..32 only).
REQ-002 Parameter SYNC_STAGES, default 2, meaning flip-flop depth of the rx_in synchronizer (2 or 3).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rx_tick  input  1  one-clk-wide oversample enable from the baud generator; OVERSAMPLE pulses per bit.
REQ-006 rx_in  input  1  asynchronous serial line, idle high, 8N1 framing (8E1 with PARITY_EN), LSB first.
REQ-007 rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-008 data_out  output  8  last good received byte.
REQ-009 rx_valid  output  1  data_out holds an unacknowledged byte.
REQ-010 rx_busy  output  1  high in any state other than IDLE.
REQ-011 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-012 overrun  output  1  one-clk pulse: byte overwritten while rx_valid high.
REQ-013 parity_err  output  1  one-clk pulse: parity mismatch; constant 0 without PARITY_EN.

Function
REQ-014 rx_in SHALL pass through SYNC_STAGES flops (reset value 1) before any use; the FSM sees only the synchronized value rxs.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and BREAK; the tick counter and bit counter SHALL advance only on clks where rx_tick=1.
REQ-016 IDLE -> START on the first rx_tick where rxs=0; the tick counter SHALL clear to 0.
REQ-017 START: at tick count OVERSAMPLE/2-1, rxs=0 -> DATA with counters cleared; rxs=1 -> IDLE (glitch rejected, no flag, no output change).
REQ-018 DATA: every OVERSAMPLE ticks after mid-start, sample rxs into a shift register LSB first; after 8 bits -> PARITY (PARITY_EN) or STOP.
REQ-019 PARITY: sample one bit OVERSAMPLE ticks later; XOR of 8 data bits and the parity bit != 0 SHALL mark the frame parity-bad; -> STOP.
REQ-020 STOP: sample OVERSAMPLE ticks later; rxs=1 and not parity-bad -> load data_out, set rx_valid, -> IDLE.
REQ-021 STOP with rxs=1 and parity-bad -> parity_err pulse, data_out and rx_valid unchanged, -> IDLE.
REQ-022 STOP with rxs=0 -> frame_err pulse, data discarded, -> BREAK; BREAK -> IDLE on first rx_tick with rxs=1.
REQ-023 Latency: data_out/rx_valid update on the clk edge following the stop-bit mid-sample rx_tick.
REQ-024 rx_valid SHALL stay high until a clk with rx_ack=1, then clear on the next edge; rx_ack while rx_valid=0 SHALL be ignored.
REQ-025 Good frame completing with rx_valid=1 and rx_ack=0 -> data_out overwritten, rx_valid stays 1, overrun pulses.
REQ-026 Good frame completing in the same clk as rx_ack=1 -> new data loaded, rx_valid stays 1, no overrun.
REQ-027 All error pulses SHALL be exactly one clk wide; only one of frame_err, parity_err, overrun may assert per frame.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, counters 0, synchronizer flops 1, data_out=8'h00, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, parity_err=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte; after release the receiver SHALL wait for a fresh falling edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: PARITY state is used, frame is 8E1 (even parity), and parity_err is driven per REQ-019/021.
REQ-031 UART_RX_PARITY_EN undefined: PARITY state and parity logic are absent, DATA goes directly to STOP, and parity_err is tied to 0.

Verification
REQ-032 8N1 frame 0xA5, OVERSAMPLE=16 -> data_out=8'hA5, rx_valid=1 one clk after stop mid-sample, rx_busy low afterwards, no error pulses.
REQ-033 rx_in low for 4 rx_ticks, then high -> back to IDLE, rx_valid=0, no error pulses, data_out unchanged.
REQ-034 Frame 0x55 with stop bit driven 0 for 20 bit times -> one frame_err pulse, rx_valid=0, FSM stays in BREAK until line high, next frame 0x12 received correctly.
REQ-035 Frames 0x3C then 0xC3 with no rx_ack -> one overrun pulse, data_out=8'hC3, rx_valid=1; rx_ack -> rx_valid=0 next clk.
REQ-036 UART_RX_PARITY_EN defined, byte 0x01 sent with parity bit 0 -> one parity_err pulse, rx_valid=0; sent with parity bit 1 -> data_out=8'h01.
REQ-037 rst pulsed low after 4 data bits of 0xFF -> all outputs at reset values; subsequent frame 0x81 -> data_out=8'h81.

Source files
------------

// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver: 8N1 framing, or 8E1 when UART_RX_PARITY_EN is defined.
// Single-entry output buffer with acknowledge handshake plus framing/overrun/parity pulses.
module uart_rx_frame #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_tick,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BREAK = 3'd4, PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BREAK = 3'd4
  } state_t;
`endif

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          tick_q;
  logic [TW-1:0]          tick_d;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;
  logic [7:0]             shift_d;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   ferr_q;
  logic                   ovr_q;
  logic                   rxs;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q;
  logic                   pbad_q;
`endif

  // Metastability guard: the line idles high, so the chain resets to ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign tick_d  = tick_q + TW'(1);
  assign shift_d = {rxs, shift_q[7:1]};

  // Receive FSM; counters only move on oversample ticks, flags are one-clk pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (rx_ack && valid_q) begin
        valid_q <= 1'b0;
      end
      if (rx_tick) begin
        case (state_q)
          IDLE: begin
            if (!rxs) begin
              state_q <= START;
              tick_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (tick_q == TICK_MID) begin
              tick_q <= '0;
              bit_q  <= 3'd0;
              if (!rxs) begin
                state_q <= DATA;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_q <= tick_d;
            end
          end
          DATA: begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              shift_q <= shift_d;
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end else begin
              tick_q <= tick_d;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              pbad_q  <= (^shift_q) ^ rxs;
              state_q <= STOP;
            end else begin
              tick_q <= tick_d;
            end
          end
`endif
          STOP: begin
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              if (rxs) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                if (pbad_q) begin
                  perr_q <= 1'b1;
                end else begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                  ovr_q   <= valid_q & ~rx_ack;
                end
`else
                data_q  <= shift_q;
                valid_q <= 1'b1;
                ovr_q   <= valid_q & ~rx_ack;
`endif
              end else begin
                ferr_q  <= 1'b1;
                state_q <= BREAK;
              end
            end else begin
              tick_q <= tick_d;
            end
          end
          BREAK: begin
            if (rxs) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out  = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
